// File: rtl/gcm_pkg.sv
// Shared GF(2^128) constants and FSM state type for the GHASH multiplier.
// Bit 0 of every block is the x^0 coefficient (GCM bit order).
package gcm_pkg;
  localparam int GCM_W = 128;
  localparam logic [0:GCM_W-1] GCM_R = {8'hE1, 120'd0};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } gcm_state_e;
endpackage

// File: rtl/gfmul_step.sv
// One bit of the GCM shift-and-add multiply.
// Folds V into Z when the X bit is set, then multiplies V by x mod P.
module gfmul_step
  import gcm_pkg::*;
(
  input  logic             x_bit,
  input  logic [0:GCM_W-1] z,
  input  logic [0:GCM_W-1] v,
  output logic [0:GCM_W-1] z_next,
  output logic [0:GCM_W-1] v_next
);
  assign z_next = x_bit ? (z ^ v) : z;
  assign v_next = (v >> 1) ^ (v[GCM_W-1] ? GCM_R : '0);
endmodule

// File: rtl/gfmul_digit.sv
// Digit-serial GF(2^128) multiplier Z = X*H with valid/ready handshakes.
// Define GFMUL_GHASH_ACC_EN to fold the previous result Y into each operand.
module gfmul_digit
  import gcm_pkg::*;
#(
  parameter int DIGIT = 4
) (
  input  logic         iClk,
  input  logic         iRstn,
  input  logic [0:127] iHashkey,
  input  logic         iHashkey_load,
  input  logic [0:127] iData,
  input  logic         iData_valid,
  input  logic         iAcc_clear,
  output logic         oData_ready,
  output logic [0:127] oResult,
  output logic         oResult_valid,
  input  logic         iResult_ready
);
  localparam int N  = GCM_W / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  gcm_state_e state;
  logic hkey_ok;
  logic [0:GCM_W-1] h_q;
  logic [0:GCM_W-1] x_q;
  logic [0:GCM_W-1] v_q;
  logic [0:GCM_W-1] z_q;
  logic [CW-1:0] cnt;
  logic [0:GCM_W-1] operand;
  logic [0:GCM_W-1] z_nx;
  logic [0:GCM_W-1] v_nx;
  logic key_load;
  logic accept;
  logic last;

  assign key_load = iHashkey_load & (state != BUSY);
  assign oData_ready = (state == IDLE) & hkey_ok & ~iHashkey_load;
  assign accept = iData_valid & oData_ready;
  assign last = (cnt == CW'(N - 1));
  assign oResult = z_q;
  assign oResult_valid = (state == DONE);

  // X is shifted by a digit per cycle, so the live bits are always x_q[0 +: DIGIT].
  for (genvar j = 0; j < DIGIT; j++) begin : g_step
    logic [0:GCM_W-1] z_i;
    logic [0:GCM_W-1] v_i;
    logic [0:GCM_W-1] z_o;
    logic [0:GCM_W-1] v_o;
    if (j == 0) begin : g_first
      assign z_i = z_q;
      assign v_i = v_q;
    end else begin : g_next
      assign z_i = g_step[j-1].z_o;
      assign v_i = g_step[j-1].v_o;
    end
    gfmul_step u_step (
      .x_bit  (x_q[j]),
      .z      (z_i),
      .v      (v_i),
      .z_next (z_o),
      .v_next (v_o)
    );
  end

  assign z_nx = g_step[DIGIT-1].z_o;
  assign v_nx = g_step[DIGIT-1].v_o;

`ifdef GFMUL_GHASH_ACC_EN
  logic [0:GCM_W-1] y_q;

  assign operand = iData ^ (iAcc_clear ? '0 : y_q);

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      y_q <= '0;
    end else if (key_load) begin
      y_q <= '0;
    end else if ((state == BUSY) && last) begin
      y_q <= z_nx;
    end
  end
`else
  logic unused_acc;

  assign operand = iData;
  assign unused_acc = iAcc_clear;
`endif

  always_ff @(posedge iClk or negedge iRstn) begin
    if (!iRstn) begin
      state   <= IDLE;
      hkey_ok <= 1'b0;
      h_q     <= '0;
      x_q     <= '0;
      v_q     <= '0;
      z_q     <= '0;
      cnt     <= '0;
    end else begin
      if (key_load) begin
        h_q     <= iHashkey;
        hkey_ok <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (accept) begin
            x_q   <= operand;
            v_q   <= h_q;
            z_q   <= '0;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          z_q <= z_nx;
          v_q <= v_nx;
          x_q <= x_q << DIGIT;
          if (last) begin
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (iResult_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gfmul_digit.sv
// Self-checking bench for gfmul_digit against a polynomial-arithmetic model.
// Works with or without GFMUL_GHASH_ACC_EN defined.
module tb_gfmul_digit;
  localparam int DIGIT = 4;
  localparam int N = 128 / DIGIT;

  logic iClk = 1'b0;
  logic iRstn = 1'b0;
  logic [0:127] iHashkey = '0;
  logic iHashkey_load = 1'b0;
  logic [0:127] iData = '0;
  logic iData_valid = 1'b0;
  logic iAcc_clear = 1'b0;
  logic oData_ready;
  logic [0:127] oResult;
  logic oResult_valid;
  logic iResult_ready = 1'b0;

  int n_tests = 0;
  int n_fail = 0;
  logic [0:127] m_h = '0;
  logic [0:127] m_y = '0;

  gfmul_digit #(.DIGIT(DIGIT)) dut (
    .iClk          (iClk),
    .iRstn         (iRstn),
    .iHashkey      (iHashkey),
    .iHashkey_load (iHashkey_load),
    .iData         (iData),
    .iData_valid   (iData_valid),
    .iAcc_clear    (iAcc_clear),
    .oData_ready   (oData_ready),
    .oResult       (oResult),
    .oResult_valid (oResult_valid),
    .iResult_ready (iResult_ready)
  );

  always #5 iClk = ~iClk;

  // Carry-less polynomial product reduced mod x^128 + x^7 + x^2 + x + 1.
  function automatic logic [0:127] gmul(input logic [0:127] a,
                                        input logic [0:127] b);
    logic [254:0] p;
    logic [254:0] bp;
    logic [0:127] r;
    p = '0;
    bp = '0;
    for (int k = 0; k < 128; k++) bp[k] = b[k];
    for (int i = 0; i < 128; i++) if (a[i]) p = p ^ (bp << i);
    for (int d = 254; d >= 128; d--) begin
      if (p[d]) begin
        p[d] = 1'b0;
        p[d-121] = ~p[d-121];
        p[d-126] = ~p[d-126];
        p[d-127] = ~p[d-127];
        p[d-128] = ~p[d-128];
      end
    end
    for (int k = 0; k < 128; k++) r[k] = p[k];
    return r;
  endfunction

  function automatic logic [0:127] exp_operand(input logic [0:127] x,
                                               input logic c);
`ifdef GFMUL_GHASH_ACC_EN
    return c ? x : (x ^ m_y);
`else
    return x;
`endif
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic load_key(input logic [0:127] k);
    @(negedge iClk);
    iHashkey = k;
    iHashkey_load = 1'b1;
    @(negedge iClk);
    iHashkey_load = 1'b0;
    m_h = k;
    m_y = '0;
  endtask

  task automatic run_block(input logic [0:127] x, input logic c,
                           input int pulse_at, input logic [0:127] hk2,
                           output logic [0:127] z, output int lat,
                           output bit to);
    int w;
    to = 1'b0;
    @(negedge iClk);
    iData = x;
    iAcc_clear = c;
    iData_valid = 1'b1;
    w = 0;
    while (!oData_ready && w < 20) begin
      @(negedge iClk);
      w++;
    end
    if (!oData_ready) to = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    iData_valid = 1'b0;
    iData = ~x;
    iAcc_clear = ~c;
    lat = 0;
    while (!oResult_valid && lat < 300) begin
      if (lat == pulse_at) begin
        iHashkey = hk2;
        iHashkey_load = 1'b1;
      end
      @(negedge iClk);
      iHashkey_load = 1'b0;
      lat++;
    end
    if (!oResult_valid) to = 1'b1;
    z = oResult;
  endtask

  task automatic consume();
    @(negedge iClk);
    iResult_ready = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    iResult_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_tests++;
    if (oResult !== '0 || oResult_valid !== 1'b0 || oData_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got res=%h v=%b rdy=%b required 0/0/0",
               oResult, oResult_valid, oData_ready);
    end
    @(negedge iClk);
    iRstn = 1'b1;
    iData_valid = 1'b1;
    repeat (3) begin
      @(negedge iClk);
      n_tests++;
      if (oData_ready !== 1'b0 || oResult_valid !== 1'b0 || oResult !== '0) begin
        n_fail++;
        $display("FAIL nokey_idle: got rdy=%b v=%b res=%h required 0/0/0",
                 oData_ready, oResult_valid, oResult);
      end
    end
    iData_valid = 1'b0;
  endtask

  task automatic test_identity();
    logic [0:127] x;
    logic [0:127] z;
    int lat;
    bit to;
    x = 128'h0388dace60b6a392f328c2b971b2fe78;
    load_key(128'h80000000000000000000000000000000);
    run_block(x, 1'b1, -1, '0, z, lat, to);
    n_tests++;
    if (to || z !== x) begin
      n_fail++;
      $display("FAIL identity_z: got %h required %h (timeout=%0d)", z, x, to);
    end
    n_tests++;
    if (lat != N) begin
      n_fail++;
      $display("FAIL identity_latency: got %0d required %0d", lat, N);
    end
    n_tests++;
    if (oData_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL done_ready: got %b required 0", oData_ready);
    end
    m_y = x;
    consume();
    n_tests++;
    if (oResult_valid !== 1'b0 || oData_ready !== 1'b1 || oResult !== x) begin
      n_fail++;
      $display("FAIL after_handshake: got v=%b rdy=%b res=%h required 0/1/%h",
               oResult_valid, oData_ready, oResult, x);
    end
  endtask

  task automatic test_gcm_vector();
    logic [0:127] z;
    logic [0:127] e;
    int lat;
    bit to;
    load_key(128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    run_block(128'h0388dace60b6a392f328c2b971b2fe78, 1'b1, -1, '0, z, lat, to);
    e = 128'h5e2ec746917062882c85b0685353deb7;
    n_tests++;
    if (to || z !== e) begin
      n_fail++;
      $display("FAIL gcm_tc2: got %h required %h", z, e);
    end
    m_y = e;
    consume();
`ifdef GFMUL_GHASH_ACC_EN
    e = 128'hf38cbb1ad69223dcc3457ae5b6b0f885;
`else
    e = gmul(128'h00000000000000000000000000000080, m_h);
`endif
    run_block(128'h00000000000000000000000000000080, 1'b0, -1, '0, z, lat, to);
    n_tests++;
    if (to || z !== e) begin
      n_fail++;
      $display("FAIL gcm_len_block: got %h required %h", z, e);
    end
    m_y = e;
    consume();
  endtask

  task automatic test_random();
    logic [0:127] x;
    logic [0:127] z;
    logic [0:127] e;
    logic c;
    int lat;
    bit to;
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 0) load_key(rnd128());
      x = rnd128();
      c = 1'($urandom_range(0, 1));
      e = gmul(exp_operand(x, c), m_h);
      run_block(x, c, -1, '0, z, lat, to);
      n_tests++;
      if (to || z !== e || lat != N) begin
        n_fail++;
        $display("FAIL random_%0d: got %h lat %0d required %h lat %0d",
                 i, z, lat, e, N);
      end
      m_y = e;
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [0:127] x;
    logic [0:127] z;
    logic [0:127] e;
    int lat;
    bit to;
    x = rnd128();
    e = gmul(exp_operand(x, 1'b1), m_h);
    run_block(x, 1'b1, -1, '0, z, lat, to);
    n_tests++;
    if (to || z !== e) begin
      n_fail++;
      $display("FAIL bp_result: got %h required %h", z, e);
    end
    iData_valid = 1'b1;
    iData = rnd128();
    for (int k = 0; k < 20; k++) begin
      @(negedge iClk);
      n_tests++;
      if (oResult !== e || oResult_valid !== 1'b1 || oData_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got res=%h v=%b rdy=%b required %h/1/0",
                 k, oResult, oResult_valid, oData_ready, e);
      end
    end
    iData_valid = 1'b0;
    iResult_ready = 1'b1;
    @(posedge iClk);
    @(negedge iClk);
    iResult_ready = 1'b0;
    n_tests++;
    if (oResult_valid !== 1'b0 || oData_ready !== 1'b1 || oResult !== e) begin
      n_fail++;
      $display("FAIL bp_release: got v=%b rdy=%b res=%h required 0/1/%h",
               oResult_valid, oData_ready, oResult, e);
    end
    m_y = e;
  endtask

  task automatic test_key_in_busy();
    logic [0:127] h1;
    logic [0:127] h2;
    logic [0:127] x;
    logic [0:127] z;
    logic [0:127] e;
    logic c;
    int lat;
    bit to;
    h1 = rnd128();
    h2 = rnd128();
    load_key(h1);
    x = rnd128();
    e = gmul(exp_operand(x, 1'b1), h1);
    run_block(x, 1'b1, 3, h2, z, lat, to);
    n_tests++;
    if (to || z !== e) begin
      n_fail++;
      $display("FAIL busy_load_old_h: got %h required %h", z, e);
    end
    m_y = e;
    consume();
    load_key(h2);
    x = rnd128();
    c = 1'($urandom_range(0, 1));
    e = gmul(exp_operand(x, c), h2);
    run_block(x, c, -1, '0, z, lat, to);
    n_tests++;
    if (to || z !== e) begin
      n_fail++;
      $display("FAIL idle_load_new_h: got %h required %h", z, e);
    end
    m_y = e;
    consume();
  endtask

  task automatic test_load_and_valid();
    logic [0:127] hk;
    logic [0:127] x;
    logic [0:127] z;
    logic [0:127] e;
    int lat;
    hk = rnd128();
    x = rnd128();
    @(negedge iClk);
    iHashkey = hk;
    iHashkey_load = 1'b1;
    iData = x;
    iAcc_clear = 1'b0;
    iData_valid = 1'b1;
    #1;
    n_tests++;
    if (oData_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL load_blocks_ready: got %b required 0", oData_ready);
    end
    @(negedge iClk);
    iHashkey_load = 1'b0;
    m_h = hk;
    m_y = '0;
    #1;
    n_tests++;
    if (oData_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL ready_after_load: got %b required 1", oData_ready);
    end
    e = gmul(exp_operand(x, 1'b0), m_h);
    @(posedge iClk);
    @(negedge iClk);
    iData_valid = 1'b0;
    iData = ~x;
    lat = 0;
    while (!oResult_valid && lat < 300) begin
      @(negedge iClk);
      lat++;
    end
    z = oResult;
    n_tests++;
    if (z !== e || lat != N) begin
      n_fail++;
      $display("FAIL load_then_accept: got %h lat %0d required %h lat %0d",
               z, lat, e, N);
    end
    m_y = e;
    consume();
  endtask

  task automatic test_reset_mid_busy();
    logic [0:127] x;
    logic [0:127] z;
    logic [0:127] e;
    int w;
    int lat;
    bit to;
    load_key(rnd128());
    @(negedge iClk);
    iData = rnd128();
    iAcc_clear = 1'b1;
    iData_valid = 1'b1;
    w = 0;
    while (!oData_ready && w < 20) begin
      @(negedge iClk);
      w++;
    end
    @(posedge iClk);
    @(negedge iClk);
    iData_valid = 1'b0;
    repeat (N / 2 - 1) @(negedge iClk);
    iRstn = 1'b0;
    #1;
    n_tests++;
    if (oResult !== '0 || oResult_valid !== 1'b0 || oData_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy_outputs: got res=%h v=%b rdy=%b required 0/0/0",
               oResult, oResult_valid, oData_ready);
    end
    m_y = '0;
    @(negedge iClk);
    iRstn = 1'b1;
    iData_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge iClk);
      n_tests++;
      if (oData_ready !== 1'b0 || oResult_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_needs_key_%0d: got rdy=%b v=%b required 0/0",
                 k, oData_ready, oResult_valid);
      end
    end
    iData_valid = 1'b0;
    load_key(rnd128());
    x = rnd128();
    e = gmul(exp_operand(x, 1'b0), m_h);
    run_block(x, 1'b0, -1, '0, z, lat, to);
    n_tests++;
    if (to || z !== e) begin
      n_fail++;
      $display("FAIL rst_recover: got %h required %h", z, e);
    end
    m_y = e;
    consume();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge iClk);
    test_reset();
    test_identity();
    test_gcm_vector();
    test_random();
    test_backpressure();
    test_key_in_busy();
    test_load_and_valid();
    test_reset_mid_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
